// File: rtl/cdc_bus_rx_arb.sv
// Receive side of a multi-channel toggle-handshake bus CDC, merged round-robin onto one valid/ready stream.
// Define CDC_BUS_RX_ARB_CNT_EN to add the xfer_cnt / busy_max statistics ports.
module cdc_bus_rx_arb #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DELAY    = 2,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  input  logic [CHANNELS-1:0]       tx_st,
  input  logic [CHANNELS*WIDTH-1:0] tx_data,
  output logic [CHANNELS-1:0]       rx_st,
  output logic [WIDTH-1:0]          dout,
  output logic [CW-1:0]             dout_ch,
  output logic                      dout_valid,
  input  logic                      dout_ready
`ifdef CDC_BUS_RX_ARB_CNT_EN
  ,
  output logic [15:0]               xfer_cnt,
  output logic [CW:0]               busy_max
`endif
);

  logic [CHANNELS-1:0] sync_q [DELAY];
  logic [CHANNELS-1:0] t2r;
  logic [CHANNELS-1:0] pending;
  logic [WIDTH-1:0]    chan_data [CHANNELS];

  logic [CHANNELS-1:0] rx_st_q, rx_st_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic [CW-1:0]       dout_ch_q, dout_ch_d;
  logic                dout_valid_q, dout_valid_d;
  logic [CW-1:0]       ptr_q, ptr_d;

  logic                slot_free;
  logic                gnt_found;
  logic [CW-1:0]       gnt_idx;
  logic [CW-1:0]       idx_v;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_words
    assign chan_data[c] = tx_data[c*WIDTH +: WIDTH];
  end

  assign t2r     = sync_q[DELAY-1];
  assign pending = rx_st_q ^ t2r;

  // Round-robin pick: first pending channel after the last one served.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_v     = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx_v = CW'((32'(ptr_q) + i) % CHANNELS);
      if (!gnt_found && pending[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_v;
      end
    end
  end

  always_comb begin
    slot_free    = !dout_valid_q || dout_ready;
    rx_st_d      = rx_st_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    ptr_d        = ptr_q;
    if (slot_free) begin
      if (gnt_found) begin
        dout_d           = chan_data[gnt_idx];
        dout_ch_d        = gnt_idx;
        dout_valid_d     = 1'b1;
        rx_st_d[gnt_idx] = t2r[gnt_idx];
        ptr_d            = gnt_idx;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  // Ack toggles back only when the word is taken into the output slot.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      for (int unsigned s = 0; s < DELAY; s++) sync_q[s] <= '0;
      rx_st_q      <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      ptr_q        <= CW'(CHANNELS - 1);
    end else begin
      sync_q[0] <= tx_st;
      for (int unsigned s = 1; s < DELAY; s++) sync_q[s] <= sync_q[s-1];
      rx_st_q      <= rx_st_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rx_st      = rx_st_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;

`ifdef CDC_BUS_RX_ARB_CNT_EN
  localparam int unsigned CNTW = CW + 1;

  logic [15:0]   xfer_cnt_q, xfer_cnt_d;
  logic [CW:0]   busy_max_q, busy_max_d;
  logic [CW:0]   pend_cnt;

  always_comb begin
    pend_cnt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) pend_cnt = pend_cnt + CNTW'(pending[c]);
    xfer_cnt_d = xfer_cnt_q;
    if (dout_valid_q && dout_ready && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
    busy_max_d = (pend_cnt > busy_max_q) ? pend_cnt : busy_max_q;
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      xfer_cnt_q <= '0;
      busy_max_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      busy_max_q <= busy_max_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign busy_max = busy_max_q;
`endif

endmodule

// File: tb/tb_cdc_bus_rx_arb.sv
// Directed bench for cdc_bus_rx_arb: latency, round robin, backpressure, toggle-back, reset mid-transfer.
module tb_cdc_bus_rx_arb;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DELAY    = 2;
  localparam int unsigned CW       = 2;

  logic                      rx_clk = 1'b0;
  logic                      rx_rst;
  logic [CHANNELS-1:0]       tx_st;
  logic [CHANNELS*WIDTH-1:0] tx_data;
  logic [CHANNELS-1:0]       rx_st;
  logic [WIDTH-1:0]          dout;
  logic [CW-1:0]             dout_ch;
  logic                      dout_valid;
  logic                      dout_ready;
`ifdef CDC_BUS_RX_ARB_CNT_EN
  logic [15:0]               xfer_cnt;
  logic [CW:0]               busy_max;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 rx_clk = ~rx_clk;

  cdc_bus_rx_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DELAY(DELAY)) dut (
    .rx_clk     (rx_clk),
    .rx_rst     (rx_rst),
    .tx_st      (tx_st),
    .tx_data    (tx_data),
    .rx_st      (rx_st),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef CDC_BUS_RX_ARB_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt),
    .busy_max   (busy_max)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic set_data(input int c, input logic [WIDTH-1:0] v);
    tx_data[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rx_rst     = 1'b1;
    tx_st      = '0;
    dout_ready = 1'b1;
    step(1);
    rx_rst = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [WIDTH-1:0] d, input logic [CW-1:0] ch);
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(d));
    check({tag, "_ch"}, 32'(dout_ch), 32'(ch));
  endtask

  task automatic wait_ack(input int c, input logic v, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (rx_st[c] !== v && cyc < 20);
    check("ack_wait", 32'(rx_st[c]), 32'(v));
  endtask

  initial begin
    int cyc;
    rx_rst     = 1'b1;
    tx_st      = '0;
    tx_data    = '0;
    dout_ready = 1'b1;
    step(1);
    check("rst_state", 32'({dout_valid, dout_ch, dout, rx_st}), 32'd0);
    rx_rst = 1'b0;

    // Single word: valid exactly DELAY+1 edges after the toggle, no duplicate
    set_data(0, 8'hA5);
    tx_st[0] = 1'b1;
    step(1); check("sw_e1", 32'(dout_valid), 32'd0);
    step(1); check("sw_e2", 32'(dout_valid), 32'd0);
    step(1); expect_word("sw", 8'hA5, 2'd0);
    check("sw_ack", 32'(rx_st), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("sw_nodup", 32'(dout_valid), 32'd0);
    end

    // Round robin from reset, then a partial re-arm
    do_reset();
    for (int c = 0; c < 4; c++) set_data(c, 8'(8'h11 * (c + 1)));
    tx_st = 4'hF;
    step(2);
    for (int c = 0; c < 4; c++) begin
      step(1);
      expect_word("rr", 8'(8'h11 * (c + 1)), 2'(c));
    end
    step(1);
    check("rr_idle", 32'(dout_valid), 32'd0);
    check("rr_ack", 32'(rx_st), 32'hF);
    set_data(0, 8'h55);
    set_data(2, 8'h77);
    tx_st = 4'b1010;
    step(3); expect_word("rr2a", 8'h55, 2'd0);
    step(1); expect_word("rr2b", 8'h77, 2'd2);
    step(1); check("rr2_idle", 32'(dout_valid), 32'd0);

    // Backpressure: held word stays stable, second channel is not acked
    do_reset();
    dout_ready = 1'b0;
    set_data(1, 8'h5C);
    tx_st = 4'b0010;
    step(3);
    expect_word("bp", 8'h5C, 2'd1);
    check("bp_ack", 32'(rx_st), 32'h2);
    set_data(2, 8'h9E);
    tx_st = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("bp_hold", 32'({dout_valid, dout_ch, dout, rx_st}), 32'({1'b1, 2'd1, 8'h5C, 4'b0010}));
    end
    dout_ready = 1'b1;
    step(1);
    expect_word("bp_rel", 8'h9E, 2'd2);
    check("bp_rel_ack", 32'(rx_st), 32'h6);
    step(1);
    check("bp_idle", 32'(dout_valid), 32'd0);

    // Toggle-back on ch3: 0->1 then 1->0
    do_reset();
    set_data(3, 8'h01);
    tx_st[3] = 1'b1;
    wait_ack(3, 1'b1, cyc);
    check("tg_lat", 32'(cyc), 32'(DELAY + 1));
    expect_word("tg1", 8'h01, 2'd3);
    set_data(3, 8'h02);
    tx_st[3] = 1'b0;
    wait_ack(3, 1'b0, cyc);
    expect_word("tg2", 8'h02, 2'd3);
    step(1);
    check("tg_idle", 32'(dout_valid), 32'd0);

    // Reset mid-transfer: both sides reset, then sender left at 1
    do_reset();
    dout_ready = 1'b0;
    set_data(0, 8'hA5);
    tx_st[0] = 1'b1;
    step(3);
    expect_word("rm", 8'hA5, 2'd0);
    #2 rx_rst = 1'b1;
    tx_st = '0;
    #1 check("rm_async", 32'({dout_valid, rx_st, dout}), 32'd0);
    @(negedge rx_clk) rx_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("rm_quiet", 32'(dout_valid), 32'd0);
    end
    tx_st[0] = 1'b1;
    step(3);
    expect_word("rm2", 8'hA5, 2'd0);
    #2 rx_rst = 1'b1;
    #1 check("rm2_async", 32'({dout_valid, rx_st, dout}), 32'd0);
    @(negedge rx_clk) rx_rst = 1'b0;
    step(2);
    check("rm_redo_e", 32'(dout_valid), 32'd0);
    step(1);
    expect_word("rm_redo", 8'hA5, 2'd0);

`ifdef CDC_BUS_RX_ARB_CNT_EN
    begin
      int acc = 0;
      int loops = 0;
      rx_rst     = 1'b1;
      tx_st      = '0;
      dout_ready = 1'b1;
      #1 check("cnt_rst", 32'({xfer_cnt, busy_max}), 32'd0);
      step(1);
      rx_rst = 1'b0;
      tx_st  = 4'b0111;
      step(5);
      check("busy_max3", 32'(busy_max), 32'd3);
      while (acc < 70000 && loops < 90000) begin
        if (dout_valid && dout_ready) acc++;
        for (int c = 0; c < CHANNELS; c++)
          if (rx_st[c] === tx_st[c]) tx_st[c] = ~tx_st[c];
        step(1);
        loops++;
      end
      check("cnt_loop", 32'(acc >= 70000), 32'd1);
      step(1);
      check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_bus_rx_arb.md
Name: cdc_bus_rx_arb

Overview:
- Receive side of the toggle-handshake bus CDC, generalised to CHANNELS independent senders sharing one receiving clock domain.
- Each channel is synchronised, and its word is captured and merged through a round-robin arbiter onto one valid/ready output stream with true backpressure.
- The acknowledge toggle is returned only when the word leaves the channel, so senders are throttled by the downstream consumer.
- Sits in the rx clock domain. Each sender keeps its own tx_st/tx_data registers and its own synchroniser on the returned ack.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of sender channels (min 1).
- DELAY, 2, synchroniser stages per tx_st bit (min 2).
- CW, derived, max(1, clog2(CHANNELS)), width of the channel index.

Ports:
- rx_clk  in  1  receive-domain clock.
- rx_rst  in  1  asynchronous active-high reset.
- tx_st  in  CHANNELS  per-channel request toggle from sender domain (asynchronous).
- tx_data  in  CHANNELS*WIDTH  per-channel data, channel c at bits [c*WIDTH +: WIDTH]. Sender holds it stable while its request is pending.
- rx_st  out  CHANNELS  per-channel ack toggle returned to the sender.
- dout  out  WIDTH  output data.
- dout_ch  out  CW  channel index of dout.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert, sync release by the integrator):
  - Synchroniser chains, rx_st, dout, dout_ch and dout_valid all go to 0.
  - Round-robin pointer goes to CHANNELS-1, so channel 0 has first priority.
- Synchroniser: t2r[c] is tx_st[c] after DELAY rx_clk flops. pending[c] = (rx_st[c] != t2r[c]).
- Output slot free = !dout_valid || dout_ready.
- Grant, when the slot is free and any pending bit is set:
  - Pick the first pending channel scanning from ptr+1 upward, wrapping modulo CHANNELS.
  - Same edge: dout <= tx_data[g], dout_ch <= g, dout_valid <= 1, rx_st[g] <= t2r[g], ptr <= g.
- Slot free with nothing pending: dout_valid <= 0. dout and dout_ch hold.
- Handshake rules:
  - dout, dout_ch and dout_valid are registered and held stable while dout_valid && !dout_ready.
  - Back-to-back transfers are allowed: accept and grant happen on the same edge, giving 1 word/cycle across channels.
- At most one grant per cycle. Non-granted pending channels wait. Starvation-free: every pending channel is served within CHANNELS grants.
- Latency:
  - tx_st toggle reaches the last sync stage after DELAY rx_clk edges; dout_valid rises on the next edge, provided the slot is free and the channel wins arbitration.
  - Minimum per-channel word period is about 2*DELAY+3 of the slower clock (round-trip handshake).
- No double capture: after a grant, pending[g] is 0 until the sender toggles again, which it cannot do before seeing the new rx_st.
- Single channel (CHANNELS=1): arbiter degenerates, dout_ch is constant 0.
- Reset mid-operation: an in-flight dout word is discarded.
  - If a sender's tx_st is left at 1 while rx_st resets to 0, the word reappears after DELAY cycles and is delivered again.
  - Integrators must reset both sides together.

Optional Feature:
- Macro CDC_BUS_RX_ARB_CNT_EN.
- Defined: adds output port xfer_cnt (16 bits) and output port busy_max (CW+1 bits).
  - xfer_cnt increments on every dout_valid && dout_ready, saturating at 16'hFFFF.
  - busy_max records the peak count of simultaneously pending channels since reset.
  - Both reset to 0.
- Undefined: neither port nor logic exists. Behaviour is otherwise identical.

Test Plan:
- Single word: reset, toggle tx_st[0] with tx_data ch0=8'hA5, dout_ready=1 -> dout_valid rises exactly DELAY+1 rx_clk edges later with dout=A5, dout_ch=0; rx_st[0] becomes 1 on the same edge; no second word appears.
- Round robin: all 4 channels pending at once with data 11/22/33/44, ready=1 -> four consecutive valid cycles in order ch0,ch1,ch2,ch3. Then re-arm ch0 and ch2 only -> order ch0, ch2.
- Backpressure: ch1 word 8'h5C pending, dout_ready=0 for 10 cycles -> dout, dout_ch and dout_valid stable; rx_st[1] toggled once only; ch2 pending meanwhile is not acked until ready=1, then delivered on the next cycle.
- Toggle-back: sender sends 0x01 then 0x02 on ch3, each waiting for rx_st[3] -> dout sequence 01, 02; both tx_st values 1->0 handled (pending on inequality, not edge).
- Reset mid-transfer: assert rx_rst while dout_valid=1 -> dout_valid, rx_st and dout go to 0 immediately (async); with tx_st also reset no output follows; with tx_st held at 1 the word is redelivered DELAY+1 cycles after release.
- CNT_EN build: 70000 accepted words -> xfer_cnt=16'hFFFF; 3 channels pending together -> busy_max=3.
